serial_chunk_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder: computes sum = a + b + cin, CHUNK_W bits per cycle, LSB chunk first.

---
 rtl/adder_pkg.sv | 13 +
 rtl/chunk_adder.sv | 28 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_chunk_adder.sv | 125 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the serial chunk adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH   = 64;
    localparam int DEFAULT_CHUNK_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple-carry adder built from full_adder cells.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign o_cout = w_carry[W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: sum = a + b + cin, CHUNK_W bits per cycle, LSB chunk first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int N     = WIDTH / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t               r_state, w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a, r_b, r_sum;
    logic                 r_carry, r_cout;
    logic                 w_accept, w_last;
    logic [CHUNK_W-1:0]   w_a_chunk, w_b_chunk, w_chunk_sum;
    logic                 w_chunk_cout;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == LAST);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: defaults are assigned first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = RUN;
            RUN:     if (w_last)   w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // One adder is shared by all chunks; the counter selects which slice feeds it.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK_W +: CHUNK_W];
                w_b_chunk = r_b[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    chunk_adder #(.W(CHUNK_W)) u_chunk_adder (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
        end else if (r_state == RUN) begin
            for (int k = 0; k < N; k++) begin
                if (r_cnt == CNT_W'(k)) r_sum[k*CHUNK_W +: CHUNK_W] <= w_chunk_sum;
            end
            r_carry <= w_chunk_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_chunk_cout;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // The top chunk's MSB is the final sum sign bit, so overflow is decided on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_chunk_sum[CHUNK_W-1] != r_a[WIDTH-1]);
        end
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed self-checking bench for serial_chunk_adder (64-bit, 8-bit chunks).
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
`ifdef SERIAL_ADD_OVF_EN
    logic        overflow;
`endif

    int checks   = 0;
    int failures = 0;

    serial_chunk_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sum"},       sum,            64'd0);
        check({tag, "_cout"},      64'(cout),      64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"},       64'(overflow),  64'd0);
`endif
    endtask

    // Drive operands with in_valid for one edge (the accept edge), then drop in_valid.
    task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vc, input string tag);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
    endtask

    // Count edges after accept until out_valid; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(input string tag);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
    endtask

    task automatic check_result(input string tag, input logic [63:0] es, input logic ec, input logic eo);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   sum,            es);
        check({tag, "_cout"},  64'(cout),      64'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"},   64'(overflow),  64'(eo));
`else
        if (eo !== 1'bx) begin end
`endif
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        check_idle_reset("rst_hold");
        rst_n = 1'b1;
        tick();
        check_idle_reset("rst_rel");

        // out_ready with nothing pending must be harmless.
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check_idle_reset("spurious_ready");

        // Simple add.
        start_op(64'h1, 64'h2, 1'b0, "t2");
        wait_done("t2");
        check_result("t2", 64'h3, 1'b0, 1'b0);
        handoff("t2");

        // Carry must ripple through all eight chunks.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "t3");
        wait_done("t3");
        check_result("t3", 64'h0, 1'b1, 1'b0);
        handoff("t3");

        // Positive + positive signed overflow.
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "t4a");
        wait_done("t4a");
        check_result("t4a", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        handoff("t4a");

        // Negative + negative signed overflow with carry out.
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "t4b");
        wait_done("t4b");
        check_result("t4b", 64'h0, 1'b1, 1'b1);
        handoff("t4b");

        // Back-pressure: result held 5 cycles while a new request waits at the input.
        start_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, "t5");
        wait_done("t5");
        a = 64'h5; b = 64'h7; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_sum",   sum,            64'h0000_0001_0000_0000);
            check("t5_hold_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_drop_valid", 64'(out_valid), 64'd0);
        check("t5_idle",       64'(in_ready),  64'd1);
        start_op(64'h5, 64'h7, 1'b1, "t5b");
        wait_done("t5b");
        check_result("t5b", 64'hD, 1'b0, 1'b0);
        handoff("t5b");

        // Operands change and in_valid pulses during RUN: latched values must win.
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, "t6");
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        repeat (3) tick();
        check("t6_run_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        begin
            int lat = 3;
            for (int i = 4; i <= 20; i++) begin
                tick();
                if (out_valid) begin
                    lat = i;
                    break;
                end
            end
            check("t6_latency", 64'(lat), 64'd8);
        end
        check_result("t6", 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
        handoff("t6");

        // Reset mid-RUN aborts the operation.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "t1r");
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        check_idle_reset("rst_run");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_reset("rst_run_rel");

        // Reset in DONE discards the held result.
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "t1d");
        wait_done("t1d");
        rst_n = 1'b0;
        #2;
        check_idle_reset("rst_done");
        tick();
        rst_n = 1'b1;
        tick();

        // Block still works normally after an aborted operation.
        start_op(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b1, "t7");
        wait_done("t7");
        check_result("t7", 64'h101, 1'b0, 1'b0);
        handoff("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
